// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access sizes, FSM states, alignment helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int mem_type_num = 2;

    localparam logic [mem_type_num-1:0] LS_B = 2'd0;
    localparam logic [mem_type_num-1:0] LS_H = 2'd1;
    localparam logic [mem_type_num-1:0] LS_W = 2'd2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [mem_type_num-1:0] mem_type,
                                           input logic [1:0]              addr_lo);
        return ((mem_type == LS_H) && addr_lo[0]) ||
               ((mem_type == LS_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane select plus zero/sign extension of the returned data word.
// Latency: combinational.
// Backpressure: none.
module mem_stage_load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]         rdata,
    input  logic [1:0]              addr_lo,
    input  logic [mem_type_num-1:0] mem_type,
    input  logic                    sign,
    output logic [XLEN-1:0]         data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane, then extend it; words pass through and ignore sign.
    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (mem_type)
            LS_B:    data = {{(XLEN-8){sign & byte_lane[7]}}, byte_lane};
            LS_H:    data = {{(XLEN-16){sign & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory req/gnt/rvalid bus and registers MEM/WB values.
// Latency: non-memory op 1 cycle; load/store 1 + gnt delay + rvalid delay cycles.
// Backpressure: mem_hold freezes upstream until rvalid completes the access.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [XLEN-1:0]         MEM_result,
    input  logic [XLEN-1:0]         MEM_FD_rs2_data,
    input  logic [RADDR-1:0]        MEM_rd_addr,
    input  logic                    MEM_rmem,
    input  logic                    MEM_wmem,
    input  logic                    MEM_wen,
    input  logic [mem_type_num-1:0] MEM_mem_type,
    input  logic                    MEM_mem_sign,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [XLEN-1:0]         dmem_addr,
    output logic [XLEN-1:0]         dmem_wdata,
    output logic [3:0]              dmem_be,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [XLEN-1:0]         dmem_rdata,
    output logic                    mem_hold,
    output logic                    misalign,
    output logic [XLEN-1:0]         WB_result,
    output logic [RADDR-1:0]        WB_rd_addr,
    output logic                    WB_wen
);

    mem_state_e       state_q, state_d;
    logic [XLEN-1:0]  wb_result_q, wb_result_d;
    logic [RADDR-1:0] wb_rd_addr_q, wb_rd_addr_d;
    logic             wb_wen_q, wb_wen_d;
    logic             misalign_q, misalign_d;

    logic             mem_op, mis_hit, access, done;
    logic [XLEN-1:0]  load_data;

    // Classify the incoming op; a misaligned op never reaches the bus.
    always_comb begin
        mem_op  = MEM_rmem | MEM_wmem;
        mis_hit = mem_op & is_misaligned(MEM_mem_type, MEM_result[1:0]);
        access  = mem_op & ~mis_hit;
    end

    // Store formatting; upstream is frozen, so these stay stable for the whole access.
    always_comb begin
        dmem_addr = {MEM_result[XLEN-1:2], 2'b00};
        dmem_we   = MEM_wmem;
        case (MEM_mem_type)
            LS_B: begin
                dmem_wdata = {(XLEN/8){MEM_FD_rs2_data[7:0]}};
                dmem_be    = 4'b0001 << MEM_result[1:0];
            end
            LS_H: begin
                dmem_wdata = {(XLEN/16){MEM_FD_rs2_data[15:0]}};
                dmem_be    = 4'b0011 << {MEM_result[1], 1'b0};
            end
            default: begin
                dmem_wdata = MEM_FD_rs2_data;
                dmem_be    = 4'b1111;
            end
        endcase
    end

    mem_stage_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata    (dmem_rdata),
        .addr_lo  (MEM_result[1:0]),
        .mem_type (MEM_mem_type),
        .sign     (MEM_mem_sign),
        .data     (load_data)
    );

    // Bus FSM: next state, request and hold; reset forces req/hold low.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        mem_hold = 1'b0;
        done     = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (access) begin
                    dmem_req = 1'b1;
                    mem_hold = 1'b1;
                    state_d  = dmem_gnt ? MEM_WAIT : MEM_REQ;
                end
            end
            MEM_REQ: begin
                dmem_req = 1'b1;
                mem_hold = 1'b1;
                if (dmem_gnt) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_rvalid) begin
                    state_d = MEM_IDLE;
                    done    = 1'b1;
                end else begin
                    mem_hold = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
        if (!rstn) begin
            dmem_req = 1'b0;
            mem_hold = 1'b0;
        end
    end

    // WB next values: pass-through for ALU ops, extended data on completion, no write otherwise.
    always_comb begin
        wb_result_d  = wb_result_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_wen_d     = 1'b0;
        misalign_d   = 1'b0;
        if (state_q == MEM_IDLE && !mem_op) begin
            wb_result_d  = MEM_result;
            wb_rd_addr_d = MEM_rd_addr;
            wb_wen_d     = MEM_wen;
        end else if (state_q == MEM_IDLE && mis_hit) begin
            wb_rd_addr_d = MEM_rd_addr;
            misalign_d   = 1'b1;
        end else if (done) begin
            // A store wins over a simultaneous load and never writes back.
            wb_result_d  = MEM_wmem ? MEM_result : load_data;
            wb_rd_addr_d = MEM_rd_addr;
            wb_wen_d     = MEM_wen & ~MEM_wmem;
        end
    end

    // State and MEM/WB registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= MEM_IDLE;
            wb_result_q  <= '0;
            wb_rd_addr_q <= '0;
            wb_wen_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_result_q  <= wb_result_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_wen_q     <= wb_wen_d;
            misalign_q   <= misalign_d;
        end
    end

    assign WB_result  = wb_result_q;
    assign WB_rd_addr = wb_rd_addr_q;
    assign WB_wen     = wb_wen_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset sequences, randomized ops vs a reference model.
// Latency: each op is driven to completion with scripted gnt/rvalid delays.
// Backpressure: mem_hold cycles are counted and compared to the expected stall.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] MEM_result, MEM_FD_rs2_data;
    logic [4:0]  MEM_rd_addr;
    logic        MEM_rmem, MEM_wmem, MEM_wen;
    logic [1:0]  MEM_mem_type;
    logic        MEM_mem_sign;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_hold, misalign;
    logic [31:0] WB_result;
    logic [4:0]  WB_rd_addr;
    logic        WB_wen;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rstn(rstn),
        .MEM_result(MEM_result), .MEM_FD_rs2_data(MEM_FD_rs2_data),
        .MEM_rd_addr(MEM_rd_addr), .MEM_rmem(MEM_rmem), .MEM_wmem(MEM_wmem),
        .MEM_wen(MEM_wen), .MEM_mem_type(MEM_mem_type), .MEM_mem_sign(MEM_mem_sign),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_hold(mem_hold), .misalign(misalign),
        .WB_result(WB_result), .WB_rd_addr(WB_rd_addr), .WB_wen(WB_wen)
    );

    typedef struct {
        logic        rmem, wmem, wen;
        logic [1:0]  typ;
        logic        sign;
        logic [31:0] addr, rs2, rdata;
        logic [4:0]  rd;
        int          gnt_dly, rv_dly;
        logic        exp_acc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_res;
        logic        exp_wen, exp_mis, chk_res;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model, expressed as plain arithmetic on the access rules.
    function automatic logic ref_mis(input logic [1:0] t, input logic [31:0] a);
        return (t == LS_H && (a % 2) != 0) || (t == LS_W && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdat, input logic [31:0] a,
                                             input logic [1:0] t, input logic s);
        int     sh, bits;
        longint v;
        if (t == LS_W) return rdat;
        bits = (t == LS_B) ? 8 : 16;
        sh   = (t == LS_B) ? int'(a % 4) * 8 : int'((a % 4) / 2) * 16;
        v    = longint'(rdat >> sh) & ((64'd1 << bits) - 1);
        if (s && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] t, input logic [31:0] a);
        if (t == LS_B) return 4'(1 << (a % 4));
        if (t == LS_H) return 4'(3 << ((a % 4) / 2 * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] t, input logic [31:0] r);
        if (t == LS_B) return (r & 32'hFF) * 32'h01010101;
        if (t == LS_H) return (r & 32'hFFFF) * 32'h00010001;
        return r;
    endfunction

    // Drive one op through its whole bus transaction, then one idle cycle.
    task automatic run_op(input vec_t v, input string tag);
        int hold_n;
        hold_n          = 0;
        MEM_result      = v.addr;
        MEM_FD_rs2_data = v.rs2;
        MEM_rd_addr     = v.rd;
        MEM_rmem        = v.rmem;
        MEM_wmem        = v.wmem;
        MEM_wen         = v.wen;
        MEM_mem_type    = v.typ;
        MEM_mem_sign    = v.sign;
        dmem_rdata      = v.rdata;
        dmem_gnt        = 1'b0;
        dmem_rvalid     = 1'b0;
        if (v.exp_acc) begin
            for (int c = 0; c <= v.gnt_dly; c++) begin
                dmem_gnt = (c == v.gnt_dly);
                #1;
                chk({tag, " req"}, 32'(dmem_req), 32'd1);
                chk({tag, " addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
                if (c == 0) begin
                    chk({tag, " we"}, 32'(dmem_we), 32'(v.wmem));
                    if (v.wmem) begin
                        chk({tag, " be"}, 32'(dmem_be), 32'(v.exp_be));
                        chk({tag, " wdata"}, dmem_wdata, v.exp_wdata);
                    end
                end
                hold_n += int'(mem_hold);
                step();
            end
            dmem_gnt = 1'b0;
            for (int c = 0; c <= v.rv_dly; c++) begin
                dmem_rvalid = (c == v.rv_dly);
                #1;
                chk({tag, " req_wait"}, 32'(dmem_req), 32'd0);
                hold_n += int'(mem_hold);
                step();
            end
            dmem_rvalid = 1'b0;
        end else begin
            #1;
            chk({tag, " req_none"}, 32'(dmem_req), 32'd0);
            hold_n += int'(mem_hold);
            step();
        end
        chk({tag, " hold_cycles"}, 32'(hold_n), v.exp_acc ? 32'(1 + v.gnt_dly + v.rv_dly) : 32'd0);
        chk({tag, " wb_wen"}, 32'(WB_wen), 32'(v.exp_wen));
        chk({tag, " misalign"}, 32'(misalign), 32'(v.exp_mis));
        if (v.exp_wen) chk({tag, " wb_rd"}, 32'(WB_rd_addr), 32'(v.rd));
        if (v.chk_res) chk({tag, " wb_result"}, WB_result, v.exp_res);
        MEM_rmem = 1'b0;
        MEM_wmem = 1'b0;
        MEM_wen  = 1'b0;
        #1;
        chk({tag, " idle_hold"}, 32'(mem_hold), 32'd0);
        step();
        chk({tag, " misalign_clr"}, 32'(misalign), 32'd0);
    endtask

    initial begin
        vec_t r;
        tbl[0]  = '{0,0,1,LS_W,0,32'h0000_1234,32'h0,32'h0,5'd5,0,0, 1'b0,4'h0,32'h0,32'h0000_1234,1,0,1};
        tbl[1]  = '{1,0,1,LS_B,1,32'h0000_0103,32'h1122_3344,32'h80FF_FF00,5'd7,0,0, 1'b1,4'h8,32'h4444_4444,32'hFFFF_FF80,1,0,1};
        tbl[2]  = '{1,0,1,LS_H,0,32'h0000_0202,32'h0,32'hBEEF_0000,5'd9,2,0, 1'b1,4'hC,32'h0,32'h0000_BEEF,1,0,1};
        tbl[3]  = '{0,1,1,LS_B,0,32'h0000_0301,32'hAABB_CCDD,32'h0,5'd3,0,1, 1'b1,4'h2,32'hDDDD_DDDD,32'h0,0,0,0};
        tbl[4]  = '{1,0,1,LS_W,0,32'h0000_0402,32'h0,32'h0,5'd4,0,0, 1'b0,4'h0,32'h0,32'h0,0,1,0};
        tbl[5]  = '{0,1,0,LS_H,0,32'h0000_0302,32'h1234_ABCD,32'h0,5'd0,1,0, 1'b1,4'hC,32'hABCD_ABCD,32'h0,0,0,0};
        tbl[6]  = '{1,0,1,LS_H,1,32'h0000_0100,32'h0,32'h1234_8001,5'd10,0,2, 1'b1,4'h3,32'h0,32'hFFFF_8001,1,0,1};
        tbl[7]  = '{1,0,1,LS_B,0,32'h0000_0101,32'h0,32'h0000_F700,5'd11,1,1, 1'b1,4'h2,32'h0,32'h0000_00F7,1,0,1};
        tbl[8]  = '{1,1,1,LS_W,0,32'h0000_0500,32'hCAFE_F00D,32'h0,5'd12,0,0, 1'b1,4'hF,32'hCAFE_F00D,32'h0,0,0,0};
        tbl[9]  = '{0,1,0,LS_H,0,32'h0000_0103,32'h0,32'h0,5'd0,0,0, 1'b0,4'h0,32'h0,32'h0,0,1,0};
        tbl[10] = '{1,0,1,LS_W,1,32'h0000_0404,32'h0,32'h8000_0001,5'd13,0,0, 1'b1,4'hF,32'h0,32'h8000_0001,1,0,1};

        // Reset with a load presented: request and hold must stay low.
        rstn = 1'b0;
        MEM_result = 32'h0000_0100; MEM_FD_rs2_data = 32'h0; MEM_rd_addr = 5'd1;
        MEM_rmem = 1'b1; MEM_wmem = 1'b0; MEM_wen = 1'b1; MEM_mem_type = LS_W; MEM_mem_sign = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        step();
        step();
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst hold", 32'(mem_hold), 32'd0);
        chk("rst wb_result", WB_result, 32'd0);
        chk("rst wb_rd", 32'(WB_rd_addr), 32'd0);
        chk("rst wb_wen", 32'(WB_wen), 32'd0);
        chk("rst misalign", 32'(misalign), 32'd0);
        MEM_rmem = 1'b0; MEM_wen = 1'b0;
        rstn = 1'b1;
        step();

        for (int i = 0; i < 11; i++) run_op(tbl[i], $sformatf("v%0d", i));

        // Reset while waiting for rvalid, then a stray rvalid in IDLE.
        MEM_result = 32'h0000_0600; MEM_rd_addr = 5'd6; MEM_rmem = 1'b1; MEM_wen = 1'b1;
        MEM_mem_type = LS_W; dmem_gnt = 1'b1;
        #1;
        step();
        dmem_gnt = 1'b0;
        #1;
        chk("mid wait_hold", 32'(mem_hold), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid rst_hold", 32'(mem_hold), 32'd0);
        chk("mid rst_req", 32'(dmem_req), 32'd0);
        step();
        chk("mid wb_result", WB_result, 32'd0);
        chk("mid wb_rd", 32'(WB_rd_addr), 32'd0);
        chk("mid wb_wen", 32'(WB_wen), 32'd0);
        chk("mid misalign", 32'(misalign), 32'd0);
        rstn = 1'b1; MEM_rmem = 1'b0; MEM_wen = 1'b0;
        #1;
        chk("post idle_hold", 32'(mem_hold), 32'd0);
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("stray hold", 32'(mem_hold), 32'd0);
        chk("stray req", 32'(dmem_req), 32'd0);
        step();
        dmem_rvalid = 1'b0;
        chk("stray wb_wen", 32'(WB_wen), 32'd0);
        run_op(tbl[1], "post_rst");

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic mis;
            kind      = $urandom_range(0, 2);
            r.typ     = 2'($urandom_range(0, 2));
            r.sign    = 1'($urandom_range(0, 1));
            r.addr    = $urandom;
            r.rs2     = $urandom;
            r.rdata   = $urandom;
            r.rd      = 5'($urandom_range(1, 31));
            r.wen     = 1'($urandom_range(0, 1));
            r.gnt_dly = $urandom_range(0, 2);
            r.rv_dly  = $urandom_range(0, 2);
            r.rmem    = (kind == 1);
            r.wmem    = (kind == 2);
            mis       = (kind != 0) && ref_mis(r.typ, r.addr);
            r.exp_acc = (kind != 0) && !mis;
            r.exp_mis = mis;
            r.exp_be    = ref_be(r.typ, r.addr);
            r.exp_wdata = ref_wdata(r.typ, r.rs2);
            if (kind == 0) begin
                r.exp_res = r.addr;
                r.exp_wen = r.wen;
                r.chk_res = 1'b1;
            end else if (kind == 1 && !mis) begin
                r.exp_res = ref_load(r.rdata, r.addr, r.typ, r.sign);
                r.exp_wen = r.wen;
                r.chk_res = 1'b1;
            end else begin
                r.exp_res = 32'h0;
                r.exp_wen = 1'b0;
                r.chk_res = 1'b0;
            end
            run_op(r, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
